// File: rtl/isr_ack_controller_pkg.sv
// Shared types and helpers for the in-service register / INTA sequencer.
// The encode helper is also used by the priority resolver.
package isr_ack_controller_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACK1  = 2'd1,
    WAIT2 = 2'd2,
    ACK2  = 2'd3
  } ack_state_t;

  localparam logic [2:0] EOI_NONSPEC = 3'b001;
  localparam logic [2:0] EOI_SPEC    = 3'b011;
  localparam logic [2:0] ROT_NONSPEC = 3'b101;
  localparam logic [2:0] ROT_SPEC    = 3'b111;

  // One-hot to level number; an all-zero input encodes to 0.
  function automatic logic [2:0] encode_onehot(input logic [7:0] onehot);
    logic [2:0] idx;
    idx = '0;
    for (int i = 0; i < 8; i++) begin
      if (onehot[i]) idx = idx | 3'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/isr_ack_controller_if.sv
// Signal bundle between the resolver/CPU side and the ISR/INTA controller.
interface isr_ack_controller_if;
  logic       INTA;
  logic [7:0] irr_highest_bit;
  logic [7:0] isr_highest_bit;
  logic       auto_eoi;
  logic [4:0] icw2_base;
  logic [7:0] ocw2;
  logic       ocw2_write;
  logic [7:0] isr;
  logic [7:0] irr_clear;
  logic [1:0] number_of_ack;
  logic [7:0] data_out;
  logic       data_out_en;

  modport master (
    output INTA, irr_highest_bit, isr_highest_bit, auto_eoi, icw2_base, ocw2, ocw2_write,
    input  isr, irr_clear, number_of_ack, data_out, data_out_en
  );

  modport slave (
    input  INTA, irr_highest_bit, isr_highest_bit, auto_eoi, icw2_base, ocw2, ocw2_write,
    output isr, irr_clear, number_of_ack, data_out, data_out_en
  );
endinterface

// File: rtl/isr_ack_controller_inta_sync.sv
// Synchroniser for the asynchronous INTA pin with fall/rise detection.
// Flops reset high so a released pin never looks like an acknowledge.
module inta_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pin,
  output logic fall,
  output logic rise
);

  logic [SYNC_STAGES-1:0] chain;
  logic                   prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain <= '1;
      prev  <= 1'b1;
    end else begin
      chain <= {chain[SYNC_STAGES-2:0], pin};
      prev  <= chain[SYNC_STAGES-1];
    end
  end

  assign fall = prev & ~chain[SYNC_STAGES-1];
  assign rise = ~prev & chain[SYNC_STAGES-1];

endmodule

// File: rtl/isr_ack_controller.sv
// In-service register plus 8086-mode two-pulse INTA sequencer with OCW2 EOI handling.
// State | meaning: IDLE wait first INTA fall; ACK1 first pulse low; WAIT2 between pulses; ACK2 vector on bus.
module isr_ack_controller
  import isr_ack_controller_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  isr_ack_controller_if.slave  bus
);

  ack_state_t state, state_next;
  logic       fall, rise;
  logic       spurious, spurious_next;
  logic [7:0] ack_vec, ack_vec_next;
  logic [7:0] isr, isr_next;
  logic [7:0] irr_clear, irr_clear_next;
  logic [1:0] nack, nack_next;
  logic [7:0] dout, dout_next;
  logic       den, den_next;
  logic [7:0] ack_set, aeoi_clear, eoi_clear;

  inta_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .pin   (bus.INTA),
    .fall  (fall),
    .rise  (rise)
  );

  always_comb begin
    eoi_clear = '0;
    if (bus.ocw2_write && bus.ocw2[4:3] == 2'b00) begin
      case (bus.ocw2[7:5])
        EOI_NONSPEC, ROT_NONSPEC: eoi_clear = bus.isr_highest_bit;
        EOI_SPEC, ROT_SPEC:       eoi_clear = 8'h01 << bus.ocw2[2:0];
        default:                  eoi_clear = '0;
      endcase
    end
  end

  always_comb begin
    state_next     = state;
    spurious_next  = spurious;
    ack_vec_next   = ack_vec;
    irr_clear_next = '0;
    nack_next      = nack;
    dout_next      = dout;
    den_next       = den;
    ack_set        = '0;
    aeoi_clear     = '0;
    case (state)
      IDLE: if (fall) begin
        state_next = ACK1;
        nack_next  = 2'd1;
        // No request pending: answer with level 7 but touch neither ISR nor IRR.
        if (bus.irr_highest_bit == '0) begin
          ack_vec_next  = 8'h80;
          spurious_next = 1'b1;
        end else begin
          ack_vec_next   = bus.irr_highest_bit;
          spurious_next  = 1'b0;
          ack_set        = bus.irr_highest_bit;
          irr_clear_next = bus.irr_highest_bit;
        end
      end
      ACK1: if (rise) state_next = WAIT2;
      WAIT2: if (fall) begin
        state_next = ACK2;
        nack_next  = 2'd2;
        dout_next  = {bus.icw2_base, encode_onehot(ack_vec)};
        den_next   = 1'b1;
      end
      ACK2: if (rise) begin
        state_next = IDLE;
        nack_next  = 2'd0;
        den_next   = 1'b0;
        if (bus.auto_eoi && !spurious) aeoi_clear = ack_vec;
      end
      default: state_next = IDLE;
    endcase
    // A set of the same bit in this cycle wins over any clear.
    isr_next = (isr & ~(eoi_clear | aeoi_clear)) | ack_set;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      spurious  <= 1'b0;
      ack_vec   <= '0;
      isr       <= '0;
      irr_clear <= '0;
      nack      <= '0;
      dout      <= '0;
      den       <= 1'b0;
    end else begin
      state     <= state_next;
      spurious  <= spurious_next;
      ack_vec   <= ack_vec_next;
      isr       <= isr_next;
      irr_clear <= irr_clear_next;
      nack      <= nack_next;
      dout      <= dout_next;
      den       <= den_next;
    end
  end

  assign bus.isr           = isr;
  assign bus.irr_clear     = irr_clear;
  assign bus.number_of_ack = nack;
  assign bus.data_out      = dout;
  assign bus.data_out_en   = den;

endmodule

// File: tb/tb_isr_ack_controller.sv
// Bench for isr_ack_controller: scoreboard-checked INTA sequences plus an EOI decode table.
module tb_isr_ack_controller;

  localparam int SYNC_STAGES = 2;
  localparam int LAT = SYNC_STAGES + 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  isr_ack_controller_if bus();

  isr_ack_controller #(.SYNC_STAGES(SYNC_STAGES)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    string      name;
    logic [7:0] isr;
    logic [7:0] clr;
    logic [1:0] nack;
    logic [7:0] dout;
    logic       chk_dout;
    logic       den;
  } exp_t;

  typedef struct {
    string      name;
    logic [7:0] ocw;
    logic [7:0] hi;
    logic [7:0] exp_isr;
  } eoi_vec_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_bad = 0;

  function automatic logic [2:0] level_of(input logic [7:0] v);
    case (v)
      8'h01:   return 3'd0;
      8'h02:   return 3'd1;
      8'h04:   return 3'd2;
      8'h08:   return 3'd3;
      8'h10:   return 3'd4;
      8'h20:   return 3'd5;
      8'h40:   return 3'd6;
      default: return 3'd7;
    endcase
  endfunction

  task automatic expect_out(input string nm, input logic [7:0] isr_e, input logic [7:0] clr_e,
                            input logic [1:0] nack_e, input logic [7:0] dout_e,
                            input logic chk_d, input logic den_e);
    exp_t e;
    e.name = nm; e.isr = isr_e; e.clr = clr_e; e.nack = nack_e;
    e.dout = dout_e; e.chk_dout = chk_d; e.den = den_e;
    sb.push_back(e);
  endtask

  task automatic check_out();
    exp_t e;
    n_vec++;
    if (sb.size() == 0) begin
      n_bad++;
      $display("FAIL scoreboard: no expectation queued");
      return;
    end
    e = sb.pop_front();
    if (bus.isr !== e.isr || bus.irr_clear !== e.clr || bus.number_of_ack !== e.nack ||
        bus.data_out_en !== e.den || (e.chk_dout && bus.data_out !== e.dout)) begin
      n_bad++;
      $display("FAIL %s: got isr=%h clr=%h nack=%0d dout=%h den=%b, want isr=%h clr=%h nack=%0d dout=%h den=%b",
               e.name, bus.isr, bus.irr_clear, bus.number_of_ack, bus.data_out, bus.data_out_en,
               e.isr, e.clr, e.nack, e.dout, e.den);
    end
  endtask

  task automatic inta_edge(input logic level);
    bus.INTA = level;
    repeat (LAT) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    bus.INTA = 1'b1;
    bus.ocw2_write = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic eoi(input logic [7:0] ocw, input logic [7:0] hi);
    bus.ocw2 = ocw;
    bus.isr_highest_bit = hi;
    bus.ocw2_write = 1'b1;
    @(negedge clk);
    bus.ocw2_write = 1'b0;
  endtask

  task automatic inta_seq(input string nm, input logic [7:0] irr, input logic [4:0] base,
                          input logic aeoi, input logic [7:0] isr0, output logic [7:0] isr_f);
    logic [7:0] ack, isr1, vec;
    ack  = (irr == 8'h00) ? 8'h80 : irr;
    isr1 = isr0 | irr;
    vec  = {base, level_of(ack)};
    isr_f = (aeoi && irr != 8'h00) ? (isr1 & ~ack) : isr1;
    bus.irr_highest_bit = irr;
    bus.icw2_base = base;
    bus.auto_eoi = aeoi;
    expect_out({nm, " fall1"}, isr1, irr, 2'd1, 8'h00, 1'b0, 1'b0);
    inta_edge(1'b0);
    check_out();
    bus.irr_highest_bit = 8'h40;
    expect_out({nm, " clr_pulse_end"}, isr1, 8'h00, 2'd1, 8'h00, 1'b0, 1'b0);
    @(negedge clk);
    check_out();
    expect_out({nm, " rise1"}, isr1, 8'h00, 2'd1, 8'h00, 1'b0, 1'b0);
    inta_edge(1'b1);
    check_out();
    expect_out({nm, " fall2"}, isr1, 8'h00, 2'd2, vec, 1'b1, 1'b1);
    inta_edge(1'b0);
    check_out();
    expect_out({nm, " rise2"}, isr_f, 8'h00, 2'd0, 8'h00, 1'b0, 1'b0);
    inta_edge(1'b1);
    check_out();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    eoi_vec_t   tbl[8];
    logic [7:0] isr_m;

    tbl[0] = '{"nonspec_eoi",   8'h20, 8'h04, 8'h20};
    tbl[1] = '{"spec_eoi_5",    8'h65, 8'h04, 8'h04};
    tbl[2] = '{"rot_nonspec",   8'hA2, 8'h04, 8'h20};
    tbl[3] = '{"rot_spec_2",    8'hE2, 8'h20, 8'h20};
    tbl[4] = '{"set_priority",  8'hC5, 8'h04, 8'h24};
    tbl[5] = '{"not_ocw2",      8'h28, 8'h04, 8'h24};
    tbl[6] = '{"spec_unset_3",  8'h63, 8'h04, 8'h24};
    tbl[7] = '{"code_010",      8'h40, 8'h04, 8'h24};

    bus.INTA = 1'b1;
    bus.irr_highest_bit = 8'h00;
    bus.isr_highest_bit = 8'h00;
    bus.auto_eoi = 1'b0;
    bus.icw2_base = 5'd0;
    bus.ocw2 = 8'h00;
    bus.ocw2_write = 1'b0;

    repeat (2) @(negedge clk);
    expect_out("reset_state", 8'h00, 8'h00, 2'd0, 8'h00, 1'b1, 1'b0);
    check_out();
    rst_n = 1'b1;
    @(negedge clk);

    inta_seq("ir3", 8'h08, 5'b00001, 1'b0, 8'h00, isr_m);

    do_reset();
    inta_seq("ir3_aeoi", 8'h08, 5'b00001, 1'b1, 8'h00, isr_m);

    do_reset();
    inta_seq("prep_ir2", 8'h04, 5'b00011, 1'b0, 8'h00, isr_m);
    inta_seq("prep_ir5", 8'h20, 5'b00011, 1'b0, isr_m, isr_m);
    expect_out("eoi_0x20", 8'h20, 8'h00, 2'd0, 8'h00, 1'b0, 1'b0);
    eoi(8'h20, 8'h04);
    check_out();
    expect_out("eoi_0x65", 8'h00, 8'h00, 2'd0, 8'h00, 1'b0, 1'b0);
    eoi(8'h65, 8'h20);
    check_out();

    do_reset();
    inta_seq("prep_ir0", 8'h01, 5'b00000, 1'b0, 8'h00, isr_m);
    inta_seq("spurious", 8'h00, 5'b00010, 1'b1, isr_m, isr_m);

    do_reset();
    inta_seq("prep_ir0b", 8'h01, 5'b00000, 1'b0, 8'h00, isr_m);
    expect_out("eoi_with_set", 8'h02, 8'h02, 2'd1, 8'h00, 1'b0, 1'b0);
    bus.irr_highest_bit = 8'h02;
    bus.isr_highest_bit = 8'h01;
    bus.ocw2 = 8'h20;
    bus.INTA = 1'b0;
    repeat (LAT - 1) @(posedge clk);
    @(negedge clk);
    bus.ocw2_write = 1'b1;
    @(negedge clk);
    bus.ocw2_write = 1'b0;
    check_out();

    do_reset();
    bus.irr_highest_bit = 8'h10;
    inta_edge(1'b0);
    inta_edge(1'b1);
    expect_out("wait2_before_reset", 8'h10, 8'h00, 2'd1, 8'h00, 1'b0, 1'b0);
    check_out();
    #2 rst_n = 1'b0;
    #1;
    expect_out("async_reset_wait2", 8'h00, 8'h00, 2'd0, 8'h00, 1'b1, 1'b0);
    check_out();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    inta_seq("after_reset", 8'h08, 5'b00001, 1'b0, 8'h00, isr_m);

    for (int i = 0; i < 8; i++) begin
      do_reset();
      inta_seq({tbl[i].name, "_prep_a"}, 8'h04, 5'b10000, 1'b0, 8'h00, isr_m);
      inta_seq({tbl[i].name, "_prep_b"}, 8'h20, 5'b10000, 1'b0, isr_m, isr_m);
      expect_out(tbl[i].name, tbl[i].exp_isr, 8'h00, 2'd0, 8'h00, 1'b0, 1'b0);
      eoi(tbl[i].ocw, tbl[i].hi);
      check_out();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/isr_ack_controller.md
Name: isr_ack_controller

Overview:
- Clocked In-Service Register plus INTA-sequence controller.
- Sits directly downstream of the priority resolver. Consumes the resolver's highest pending request and highest in-service bit. Produces isr back to the resolver and the irr clear pulse to the request register.
- Runs the 8086-mode two-pulse INTA handshake, drives the interrupt vector on the data bus, and handles EOI commands from OCW2.

Parameters:
SYNC_STAGES, 2, number of flops synchronising the asynchronous INTA pin (minimum 2)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
INTA  in  1  interrupt-acknowledge pin, active low, asynchronous to clk
irr_highest_bit  in  8  one-hot highest-priority pending request from resolver (0 = none)
isr_highest_bit  in  8  one-hot highest-priority in-service bit from resolver
auto_eoi  in  1  ICW4 AEOI mode
icw2_base  in  5  vector base T7..T3
ocw2  in  8  OCW2 command byte
ocw2_write  in  1  one-cycle strobe: ocw2 valid
isr  out  8  In-Service Register
irr_clear  out  8  one-hot, one-cycle pulse clearing the acknowledged IRR bit
number_of_ack  out  2  INTA pulses seen in current sequence (0,1,2)
data_out  out  8  vector byte
data_out_en  out  1  data bus drive enable

Behaviour:
- Reset (async, rst_n=0): isr=0, irr_clear=0, number_of_ack=0, data_out=0, data_out_en=0, state=IDLE, synchroniser flops=1. Reset mid-sequence aborts the sequence; no ISR bit remains set.
- INTA is synchronised through SYNC_STAGES flops.
  - fall = previous synced value 1 and current synced value 0.
  - rise = the reverse.
  - Edge detection latency is SYNC_STAGES+1 cycles from the pin.
- State machine: IDLE, ACK1, WAIT2, ACK2.
  - IDLE, on fall:
    - latch ack_vec=irr_highest_bit;
    - isr |= ack_vec;
    - irr_clear=ack_vec for exactly one cycle;
    - number_of_ack=1;
    - go to ACK1.
  - ACK1, on rise: go to WAIT2. data_out_en stays 0 throughout the first pulse.
  - WAIT2, on fall:
    - number_of_ack=2;
    - data_out={icw2_base, encode(ack_vec)};
    - data_out_en=1 from the next cycle;
    - go to ACK2.
  - ACK2, on rise:
    - data_out_en=0 next cycle;
    - number_of_ack=0;
    - if auto_eoi, isr &= ~ack_vec;
    - go to IDLE.
- Spurious acknowledge: irr_highest_bit==0 at the first fall. isr is unchanged, irr_clear stays 0, ack_vec is forced to 8'h80, and the vector level is 7. AEOI clears nothing on a spurious acknowledge.
- EOI decode, when ocw2_write=1 and ocw2[4:3]==2'b00:
  - R,SL,EOI (ocw2[7:5]) = 001 or 101 (non-specific): clear isr_highest_bit.
  - 011 or 111 (specific): clear bit ocw2[2:0].
  - All other codes leave isr unchanged. Rotation is handled by the resolver.
- Simultaneous EOI and acknowledge-set in one cycle: isr_next = (isr & ~eoi_clear) | ack_set. A set of the same bit wins.
- An EOI for a bit that is not set is a no-op.
- A fall while in ACK1 or ACK2 is impossible by construction; ignore it.
- A rise in IDLE or WAIT2 is ignored.
- irr_highest_bit is sampled only in IDLE on fall. Later changes do not alter the vector.
- Outputs isr, number_of_ack, data_out and data_out_en are registered. irr_clear is registered.

Decomposition:
- Shared package holds:
  - state enum (IDLE, ACK1, WAIT2, ACK2);
  - OCW2 command constants (EOI_NONSPEC=3'b001, EOI_SPEC=3'b011, ROT_NONSPEC=3'b101, ROT_SPEC=3'b111);
  - the one-hot-to-3-bit encode function, reused by the resolver.
- One sub-module: inta_sync (SYNC_STAGES flop chain plus fall/rise edge detector).

Test Plan:
- IR3 pending (irr_highest_bit=8'h08), icw2_base=5'b00001, two INTA pulses -> irr_clear=8'h08 for one cycle after the first fall; isr=8'h08; data_out=8'h0B with data_out_en=1 during the second pulse; number_of_ack goes 1,1,2,0.
- Same as above with auto_eoi=1 -> isr returns to 8'h00 one cycle after the second rise.
- isr=8'h24, isr_highest_bit=8'h04, ocw2=8'h20 with strobe -> isr=8'h20. Then ocw2=8'h65 -> isr=8'h00.
- Spurious: irr_highest_bit=0 at the first fall, icw2_base=5'b00010 -> irr_clear never asserted, isr unchanged, data_out=8'h17.
- Non-specific EOI strobed in the same cycle as the first-fall set of IR1, with isr=8'h01 and isr_highest_bit=8'h01 -> isr=8'h02.
- rst_n asserted during WAIT2 with isr=8'h10 -> isr=0, data_out_en=0, number_of_ack=0 immediately. After release, a fresh two-pulse sequence completes normally.
